// File: rtl/fft_pkg.sv
// Shared constants, width helpers and FSM encoding for the FFT stage sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`timescale 1ns/1ps
package fft_pkg;

  localparam int N_DEF        = 8;
  localparam int PIPE_LAT_DEF = 3;

  // Width of the stage counter: enough bits to hold 0..log2(n)-1.
  function automatic int stg_w(input int n);
    return $clog2($clog2(n));
  endfunction

  // Width of the butterfly index counter: enough bits to hold 0..n/2-1.
  function automatic int idx_w(input int n);
    return $clog2(n / 2);
  endfunction

  function automatic int last_stg(input int n);
    return $clog2(n) - 1;
  endfunction

  function automatic int last_idx(input int n);
    return n / 2 - 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// DEPTH-deep valid/data shift register with advance enable, for pipeline alignment.
// Latency: DEPTH enabled cycles from in_* to out_*.
// Backpressure: en=0 freezes every stage; nothing is dropped or duplicated.
//
// Ports: clk, rst_n (async, active low), en (advance), in_vld/in_dat (entry),
//        out_vld/out_dat (oldest entry), vld_vec (valid bit of every stage,
//        bit 0 youngest, bit DEPTH-1 oldest).
`timescale 1ns/1ps
module fft_wb_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [W-1:0]     in_dat,
  output logic             out_vld,
  output logic [W-1:0]     out_dat,
  output logic [DEPTH-1:0] vld_vec
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];
  assign vld_vec = vld_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks butterfly index/stage for an N-point FFT, regenerates write-back pairs PIPE_LAT later.
// Latency: first read one cycle after start; write-back PIPE_LAT non-stalled cycles after its read.
// Backpressure: stall=1 freezes FSM, counters and write pipeline; rd/wr valid and done masked.
//
// Ports: clk, rst_n (async, active low), start (run request, idle only),
//        stall (global hold), busy (ISSUE or WAIT), rd_valid/rd_index/rd_stage
//        (read-side pair), wr_valid/wr_index/wr_stage (write-back pair),
//        done (one-cycle completion pulse).
`timescale 1ns/1ps
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  rd_valid,
  output logic [idx_w(N)-1:0]   rd_index,
  output logic [stg_w(N)-1:0]   rd_stage,
  output logic                  wr_valid,
  output logic [idx_w(N)-1:0]   wr_index,
  output logic [stg_w(N)-1:0]   wr_stage,
  output logic                  done
);

  localparam int IDX_W = idx_w(N);
  localparam int STG_W = stg_w(N);
  localparam int DW    = IDX_W + STG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(last_idx(N));
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(last_stg(N));
  // Every delay stage except the oldest. The oldest entry is written back in
  // the current cycle, so the next stage may start reading in the cycle after.
  localparam logic [PIPE_LAT-1:0] HAZ_MASK = {PIPE_LAT{1'b1}} >> 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [STG_W-1:0]   stg;
  logic               busy_q;
  logic               adv;
  logic               haz;
  logic               wb_vld;
  logic [DW-1:0]      wb_dat;
  logic [PIPE_LAT-1:0] wb_pend;

  assign adv = ~stall;
  // Writes still in flight for the current stage after this cycle's write-back.
  assign haz = |(wb_pend & HAZ_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      stg    <= '0;
      busy_q <= 1'b0;
    end else if (adv) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ISSUE;
            idx    <= '0;
            stg    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Explicit wrap so issue count stays N/2 regardless of counter width.
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (!haz) begin
            if (stg == LAST_STG) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
            end else begin
              stg   <= stg + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  fft_wb_delay #(
    .DEPTH (PIPE_LAT),
    .W     (DW)
  ) u_wb_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .in_vld  (rd_valid),
    .in_dat  ({idx, stg}),
    .out_vld (wb_vld),
    .out_dat (wb_dat),
    .vld_vec (wb_pend)
  );

  assign busy     = busy_q;
  assign rd_valid = (state == S_ISSUE) && adv;
  assign rd_index = idx;
  assign rd_stage = stg;
  assign wr_valid = wb_vld && adv;
  assign {wr_index, wr_stage} = wb_dat;
  // DONE is held across stall, so the pulse is deferred rather than lost.
  assign done     = (state == S_DONE) && adv;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: N=8/PIPE_LAT=3 and N=16/PIPE_LAT=1 instances.
// Latency: n/a.
// Backpressure: stall driven on the N=8 instance only.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, stall_a, start_b, stall_b;
  logic       busy_a, rd_valid_a, wr_valid_a, done_a;
  logic [1:0] rd_index_a, rd_stage_a, wr_index_a, wr_stage_a;
  logic       busy_b, rd_valid_b, wr_valid_b, done_b;
  logic [2:0] rd_index_b, wr_index_b;
  logic [1:0] rd_stage_b, wr_stage_b;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N(8), .PIPE_LAT(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall_a), .busy(busy_a),
    .rd_valid(rd_valid_a), .rd_index(rd_index_a), .rd_stage(rd_stage_a),
    .wr_valid(wr_valid_a), .wr_index(wr_index_a), .wr_stage(wr_stage_a),
    .done(done_a)
  );

  fft_stage_sequencer #(.N(16), .PIPE_LAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall_b), .busy(busy_b),
    .rd_valid(rd_valid_b), .rd_index(rd_index_b), .rd_stage(rd_stage_b),
    .wr_valid(wr_valid_b), .wr_index(wr_index_b), .wr_stage(wr_stage_b),
    .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference schedule at effective (non-stalled) cycle e of a run started at cycle 0:
  // each stage is n/2 reads followed by p cycles of drain, done after the last stage.
  task automatic exp_at(input int e, input int n, input int p,
                        output int rv, output int ri, output int rs,
                        output int wv, output int wi, output int ws,
                        output int dn, output int bz);
    int t, l, dc, r, w;
    t  = n / 2 + p;
    l  = $clog2(n);
    dc = t * l + 1;
    rv = 0; ri = 0; rs = 0; wv = 0; wi = 0; ws = 0;
    dn = (e == dc) ? 1 : 0;
    bz = (e >= 1 && e < dc) ? 1 : 0;
    r = e - 1;
    if (r >= 0 && r / t < l && r % t < n / 2) begin
      rv = 1; ri = r % t; rs = r / t;
    end
    w = e - 1 - p;
    if (w >= 0 && w / t < l && w % t < n / 2) begin
      wv = 1; wi = w % t; ws = w / t;
    end
  endtask

  task automatic check_cycle(input string nm, input bit b, input int c, input int e, input bit frozen);
    int erv, eri, ers, ewv, ewi, ews, edn, ebz;
    logic [31:0] orv, ori, ors, owv, owi, ows, odn, obz;
    string t;
    t = $sformatf("%s c%0d", nm, c);
    if (frozen) begin
      erv = 0; eri = 0; ers = 0; ewv = 0; ewi = 0; ews = 0; edn = 0; ebz = 1;
    end else begin
      exp_at(e, b ? 16 : 8, b ? 1 : 3, erv, eri, ers, ewv, ewi, ews, edn, ebz);
    end
    if (b) begin
      orv = 32'(rd_valid_b); ori = 32'(rd_index_b); ors = 32'(rd_stage_b);
      owv = 32'(wr_valid_b); owi = 32'(wr_index_b); ows = 32'(wr_stage_b);
      odn = 32'(done_b);     obz = 32'(busy_b);
    end else begin
      orv = 32'(rd_valid_a); ori = 32'(rd_index_a); ors = 32'(rd_stage_a);
      owv = 32'(wr_valid_a); owi = 32'(wr_index_a); ows = 32'(wr_stage_a);
      odn = 32'(done_a);     obz = 32'(busy_a);
    end
    chk({t, " rd_valid"}, orv, erv);
    if (erv != 0) begin
      chk({t, " rd_index"}, ori, eri);
      chk({t, " rd_stage"}, ors, ers);
    end
    chk({t, " wr_valid"}, owv, ewv);
    if (ewv != 0) begin
      chk({t, " wr_index"}, owi, ewi);
      chk({t, " wr_stage"}, ows, ews);
    end
    chk({t, " done"}, odn, edn);
    chk({t, " busy"}, obz, ebz);
    if (odn == 32'd1) done_cnt++;
  endtask

  task automatic check_zero_a(input string nm);
    chk({nm, " busy"},     32'(busy_a),     0);
    chk({nm, " rd_valid"}, 32'(rd_valid_a), 0);
    chk({nm, " rd_index"}, 32'(rd_index_a), 0);
    chk({nm, " rd_stage"}, 32'(rd_stage_a), 0);
    chk({nm, " wr_valid"}, 32'(wr_valid_a), 0);
    chk({nm, " wr_index"}, 32'(wr_index_a), 0);
    chk({nm, " wr_stage"}, 32'(wr_stage_a), 0);
    chk({nm, " done"},     32'(done_a),     0);
  endtask

  // mode 0: start only at cycle 0; 1: also at cycles 5 and 12; 2: start held high.
  // Stall window [st_lo, st_hi] applies to the N=8 instance.
  task automatic run(input string nm, input bit b, input int ncyc,
                     input int st_lo, input int st_hi, input int mode, input int exp_dones);
    int e;
    bit fz, st;
    done_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      st = (c == 0) || (mode == 1 && (c == 5 || c == 12)) || (mode == 2 && c < ncyc - 1);
      if (b) start_b = st;
      else   start_a = st;
      fz = (c >= st_lo && c <= st_hi);
      stall_a = fz;
      #1;
      e = c;
      if (st_hi >= 0 && c > st_hi) e = c - (st_hi - st_lo + 1);
      // Back-to-back: the second run starts in the cycle after IDLE (cycle 23).
      if (mode == 2 && c >= 23) e = c - 23;
      check_cycle(nm, b, c, e, fz);
    end
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0;
    chk({nm, " done count"}, 32'(done_cnt), exp_dones);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("reset");
    chk("reset b busy",     32'(busy_b),     0);
    chk("reset b rd_valid", 32'(rd_valid_b), 0);
    chk("reset b done",     32'(done_b),     0);
    rst_n = 1'b1;

    run("base", 1'b0, 26, -1, -2, 0, 1);
    run("stall", 1'b0, 28, 2, 3, 0, 1);
    run("restart_ign", 1'b0, 26, -1, -2, 1, 1);

    // Asynchronous reset in the middle of stage 1.
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      start_a = (c == 0);
      #1;
      check_cycle("pre_rst", 1'b0, c, c, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_a("rst c10");
    @(posedge clk);
    #2;
    check_zero_a("rst c11");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_zero_a("rst c12");
    chk("pre_rst done count", 32'(done_cnt), 0);
    run("rst_rerun", 1'b0, 26, -1, -2, 0, 1);

    run("n16", 1'b1, 40, -1, -2, 0, 1);
    run("held", 1'b0, 47, -1, -2, 2, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Drives the FFT stage datapath. After a start pulse it walks the butterfly index and stage counters: index 0..N/2-1 within each stage, stages 0..log2(N)-1. It issues read-side (index, stage) pairs to the index mapper and butterfly pipeline, and regenerates the matching write-back (index, stage) pairs PIPE_LAT cycles later. It enforces the inter-stage read-after-write hazard and reports completion with a done pulse.

Parameters:
N, 8, FFT size in points; power of two, >= 4
PIPE_LAT, 3, cycles from a read issue to its write-back; >= 1
Derived constants: STG_W = clog2(clog2(N)), IDX_W = clog2(N/2), LAST_STG = clog2(N)-1, LAST_IDX = N/2-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  one-cycle request to run a full FFT; ignored unless idle
stall  in  1  freezes counters, issue and write pipeline while high
busy  out  1  high from first issue cycle until last write-back cycle
rd_valid  out  1  rd_index/rd_stage valid this cycle
rd_index  out  IDX_W  butterfly index to index mapper (read side)
rd_stage  out  STG_W  stage to index mapper (read side)
wr_valid  out  1  wr_index/wr_stage valid this cycle
wr_index  out  IDX_W  butterfly index for write-back
wr_stage  out  STG_W  stage for write-back
done  out  1  one-cycle pulse after final write-back

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters 0; write delay line cleared. Reset mid-run aborts the run, and no done pulse follows.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if start=1 at edge k, go to ISSUE with idx=0, stg=0. The first rd_valid is at cycle k+1. start is ignored in every other state.
- ISSUE: each cycle with stall=0, rd_valid=1 and outputs the current idx/stg; then idx increments. When idx=LAST_IDX is issued, go to WAIT, idx wraps to 0 and stg is held.
- WAIT: no reads issued. Leave when the delay line holds no valid entry for the current stage, i.e. in the cycle after that stage's last wr_valid:
  - if stg<LAST_STG, stg increments and the state returns to ISSUE;
  - otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Write path: a PIPE_LAT-deep shift register of {valid, index, stage} advances on every stall=0 cycle. wr_* equals rd_* from PIPE_LAT non-stalled cycles earlier.
- stall=1: FSM, counters and delay line hold. rd_valid and wr_valid are forced to 0 in that cycle, and rd_index/wr_index hold their values. done may not assert during stall; it is deferred.
- busy = (state==ISSUE or WAIT), registered with the state.
- Counter widths are exact; idx wrap at LAST_IDX is explicit, not via overflow, so non-power-of-two issue counts remain correct if N changes.
- Timing for N=8, PIPE_LAT=3, start at cycle 0 with no stall:
  - stage 0: reads cycles 1-4, writes 4-7;
  - stage 1: reads 8-11, writes 11-14;
  - stage 2: reads 15-18, writes 18-21;
  - done at cycle 22.

Decomposition:
- Shared package fft_pkg: N, PIPE_LAT defaults, STG_W/IDX_W/LAST_STG/LAST_IDX functions, FSM state encoding.
- Sub-module: fft_wb_delay, a parameterised PIPE_LAT-deep valid/data shift register with enable. It is reusable for data-path alignment.
- FSM and counters stay in the top module.

Test Plan:
- N=8, PIPE_LAT=3, start at cycle 0, no stall -> rd (idx,stg) sequence (0..3,0),(0..3,1),(0..3,2) at cycles 1-4/8-11/15-18; wr at 4-7/11-14/18-21; done only at cycle 22; busy high cycles 1-21.
- Same config, stall=1 for cycles 2-3 -> no rd/wr valid in those cycles; every later event shifts by 2; done at cycle 24; sequence unchanged.
- start re-asserted at cycles 5 and 12 during a run -> ignored; exactly one done; no extra reads.
- rst_n low at cycle 10 for 2 cycles -> outputs 0 immediately (asynchronous); no done; a new start then produces the full sequence from (0,0).
- N=16, PIPE_LAT=1 -> 4 stages × 8 reads each; reads of stage s+1 start exactly 2 cycles after stage s's last read; done once.
- start held high continuously -> runs back-to-back: a new run begins the cycle after IDLE is re-entered, and each run produces exactly one done.
